// File: rtl/pid_pkg.sv
// Shared widths, defaults and saturation helpers for the steering PID.
package pid_pkg;

  localparam int ERR_W_DEF   = 12;
  localparam int FRWRD_W_DEF = 10;
  localparam int SPD_W_DEF   = 11;
  localparam int GAIN_W_DEF  = 6;
  localparam int KP_DEF_VAL  = 8;
  localparam int KD_DEF_VAL  = 11;
  localparam int I_SHIFT_DEF = 6;
  localparam int D_DEPTH_DEF = 2;

  // Internal datapath widths
  localparam int ESAT_W  = 10;
  localparam int DSAT_W  = 8;
  localparam int P_W     = 17;
  localparam int INTEG_W = 18;
  localparam int SUM_W   = 18;

  localparam int ESAT_MAX = 511;
  localparam int ESAT_MIN = -512;
  localparam int DSAT_MAX = 127;
  localparam int DSAT_MIN = -128;

  function automatic int sat_s(input int v, input int mn, input int mx);
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
  endfunction

  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int smin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pid_dhist.sv
// Derivative history: last DEPTH valid samples, oldest entry exposed.
module pid_dhist #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                shift,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest
);

  logic [DEPTH-1:0][W-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (shift) begin
      hist[0] <= din;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign oldest = $signed(hist[DEPTH-1]);

endmodule

// File: rtl/pid_gen.sv
// Steering PID: saturated error -> P/I/D terms -> differential wheel speeds.
module pid_gen
  import pid_pkg::*;
#(
  parameter int ERR_W   = ERR_W_DEF,
  parameter int FRWRD_W = FRWRD_W_DEF,
  parameter int SPD_W   = SPD_W_DEF,
  parameter int GAIN_W  = GAIN_W_DEF,
  parameter int KP_DEF  = KP_DEF_VAL,
  parameter int KD_DEF  = KD_DEF_VAL,
  parameter int I_SHIFT = I_SHIFT_DEF,
  parameter int D_DEPTH = D_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      moving,
  input  logic                      err_vld,
  input  logic signed [ERR_W-1:0]   error,
  input  logic signed [FRWRD_W-1:0] frwrd,
  input  logic                      cfg_we,
  input  logic [GAIN_W-1:0]         cfg_kp,
  input  logic [GAIN_W-1:0]         cfg_kd,
  output logic signed [SPD_W-1:0]   lft_spd,
  output logic signed [SPD_W-1:0]   rght_spd,
  output logic                      out_vld
);

  localparam int SPD_MAX = smax(SPD_W);
  localparam int SPD_MIN = smin(SPD_W);
  localparam int EXT_W   = SPD_W + 2;

  logic [GAIN_W-1:0]         kp, kd;
  logic                      sample;
  logic signed [ESAT_W-1:0]  err_sat;
  logic signed [ESAT_W-1:0]  d_old;
  logic signed [ESAT_W:0]    d_diff;
  logic signed [DSAT_W-1:0]  d_sat;
  logic signed [INTEG_W-1:0] integ, integ_sum, integ_nxt;
  logic                      integ_ovf;
  logic signed [P_W-1:0]     p_term;
  logic signed [SUM_W-1:0]   i_term, d_term, pid_sum, pid_sh;
  logic signed [SPD_W-1:0]   pid;
  logic signed [EXT_W-1:0]   l_ext, r_ext;
  logic signed [SPD_W-1:0]   lft_nxt, rght_nxt;

  assign sample = err_vld & moving;

  // Gains are registers, so a sample on the load edge still sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp <= GAIN_W'(KP_DEF);
      kd <= GAIN_W'(KD_DEF);
    end else if (cfg_we) begin
      kp <= cfg_kp;
      kd <= cfg_kd;
    end
  end

  always_comb begin
    err_sat = ESAT_W'(sat_s(int'(error), ESAT_MIN, ESAT_MAX));
    p_term  = P_W'(err_sat) * P_W'($signed({1'b0, kp}));
  end

  // Integrator holds rather than wraps on signed overflow.
  always_comb begin
    integ_sum = integ + INTEG_W'(err_sat);
    integ_ovf = (integ[INTEG_W-1] == err_sat[ESAT_W-1]) &&
                (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
    integ_nxt = integ_ovf ? integ : integ_sum;
    i_term    = integ_nxt >>> I_SHIFT;
  end

  pid_dhist #(
    .W     (ESAT_W),
    .DEPTH (D_DEPTH)
  ) u_dhist (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!moving),
    .shift  (sample),
    .din    (err_sat),
    .oldest (d_old)
  );

  always_comb begin
    d_diff = (ESAT_W+1)'(err_sat) - (ESAT_W+1)'(d_old);
    d_sat  = DSAT_W'(sat_s(int'(d_diff), DSAT_MIN, DSAT_MAX));
    d_term = SUM_W'(d_sat) * SUM_W'($signed({1'b0, kd}));
  end

  always_comb begin
    pid_sum  = SUM_W'(p_term) + i_term + d_term;
    pid_sh   = pid_sum >>> 3;
    pid      = SPD_W'(sat_s(int'(pid_sh), SPD_MIN, SPD_MAX));
    l_ext    = EXT_W'(frwrd) + EXT_W'(pid);
    r_ext    = EXT_W'(frwrd) - EXT_W'(pid);
    lft_nxt  = SPD_W'(sat_s(int'(l_ext), SPD_MIN, SPD_MAX));
    rght_nxt = SPD_W'(sat_s(int'(r_ext), SPD_MIN, SPD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ    <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
    end else if (!moving) begin
      integ    <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
    end else if (err_vld) begin
      integ    <= integ_nxt;
      lft_spd  <= lft_nxt;
      rght_spd <= rght_nxt;
      out_vld  <= 1'b1;
    end else begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pid_gen.sv
// Randomized + directed bench for pid_gen against an integer reference model.
module tb_pid_gen;

  localparam int D_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               moving = 1'b0;
  logic               err_vld = 1'b0;
  logic signed [11:0] error = '0;
  logic signed [9:0]  frwrd = '0;
  logic               cfg_we = 1'b0;
  logic [5:0]         cfg_kp = '0;
  logic [5:0]         cfg_kd = '0;
  logic signed [10:0] lft_spd, rght_spd;
  logic               out_vld;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_kp, m_kd, m_integ, m_lft, m_rght;
  bit m_vld;
  int m_hist[$];

  pid_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .cfg_we   (cfg_we),
    .cfg_kp   (cfg_kp),
    .cfg_kd   (cfg_kd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .out_vld  (out_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_integ = 0;
    m_hist.delete();
    for (int i = 0; i < D_DEPTH; i++) m_hist.push_back(0);
    m_lft = 0;
    m_rght = 0;
    m_vld = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_kp = 8;
    m_kd = 11;
  endtask

  task automatic model_edge(input bit mov, input bit vld, input int e, input int f,
                            input bit we, input int kpn, input int kdn);
    int es, p, s, i, d, pid;
    if (!mov) begin
      model_clear();
    end else if (vld) begin
      es = clamp(e, -512, 511);
      p  = es * m_kp;
      s  = m_integ + es;
      if (s <= 131071 && s >= -131072) m_integ = s;
      i   = m_integ >>> 6;
      d   = clamp(es - m_hist[0], -128, 127) * m_kd;
      pid = clamp((p + i + d) >>> 3, -1024, 1023);
      m_lft  = clamp(f + pid, -1024, 1023);
      m_rght = clamp(f - pid, -1024, 1023);
      m_hist.push_back(es);
      void'(m_hist.pop_front());
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
    if (we) begin
      m_kp = kpn;
      m_kd = kdn;
    end
  endtask

  // One clock edge: drive, advance the model, check just after the edge.
  task automatic step(input bit mov, input bit vld, input int e, input int f,
                      input bit we, input int kpn, input int kdn);
    moving  = mov;
    err_vld = vld;
    error   = e[11:0];
    frwrd   = f[9:0];
    cfg_we  = we;
    cfg_kp  = kpn[5:0];
    cfg_kd  = kdn[5:0];
    @(posedge clk);
    model_edge(mov, vld, e, f, we, kpn, kdn);
    #1;
    chk("lft_spd", lft_spd, m_lft);
    chk("rght_spd", rght_spd, m_rght);
    chk("out_vld", out_vld, 32'(m_vld));
    err_vld = 1'b0;
    cfg_we  = 1'b0;
  endtask

  initial begin
    int e, f;
    bit mov, vld, we;

    // Reset state
    model_reset();
    #1;
    chk("rst_lft", lft_spd, 0);
    chk("rst_rght", rght_spd, 0);
    chk("rst_vld", out_vld, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_kp", dut.kp, 8);
    chk("rst_kd", dut.kd, 11);

    // Single sample from cleared state
    step(1, 1, 16, 0, 0, 0, 0);
    chk("single_lft", lft_spd, 38);
    chk("single_rght", rght_spd, -38);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("single_hold", lft_spd, 38);

    // Moving drop with a pending sample, then the same sample again
    step(1, 1, 200, 50, 0, 0, 0);
    step(0, 1, 300, 50, 0, 0, 0);
    chk("drop_lft", lft_spd, 0);
    step(1, 1, 16, 0, 0, 0, 0);
    chk("redo_lft", lft_spd, 38);
    chk("redo_rght", rght_spd, -38);

    // Saturation from cleared state
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2047, 511, 0, 0, 0);
    chk("sat_lft", lft_spd, 1023);
    chk("sat_rght", rght_spd, -175);

    // Gain load on the same edge as a sample
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16, 100, 1, 0, 0);
    chk("gain_old_lft", lft_spd, 138);
    chk("gain_old_rght", rght_spd, 62);
    step(1, 1, 16, 100, 0, 0, 0);
    chk("gain_new_lft", lft_spd, 100);
    chk("gain_new_rght", rght_spd, 100);
    for (int k = 0; k < 40; k++) step(1, 1, 511, 100, 0, 0, 0);

    // Randomized traffic with occasional gain loads and moving drops
    step(1, 0, 0, 0, 1, 8, 11);
    for (int k = 0; k < 400; k++) begin
      mov = ($urandom_range(0, 29) != 0);
      vld = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 11) == 0);
      e   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4095)) - 2048
                                        : int'($urandom_range(0, 1200)) - 600;
      f   = int'($urandom_range(0, 1023)) - 512;
      step(mov, vld, e, f, we, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    // Integrator clamp at the positive limit
    step(0, 0, 0, 0, 1, 8, 11);
    for (int k = 0; k < 300; k++) step(1, 1, 511, 0, 0, 0, 0);
    chk("integ_model", dut.integ, m_integ);
    chk("integ_max", dut.integ, 130816);

    // Asynchronous reset mid-run with a sample in flight
    step(1, 1, -300, 20, 1, 3, 5);
    err_vld = 1'b1;
    error   = 12'sd100;
    moving  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_lft", lft_spd, 0);
    chk("midrst_rght", rght_spd, 0);
    chk("midrst_vld", out_vld, 0);
    @(posedge clk); #1;
    err_vld = 1'b0;
    rst_n = 1'b1;
    model_reset();
    chk("midrst_kp", dut.kp, 8);
    chk("midrst_kd", dut.kd, 11);
    step(1, 1, 16, 0, 0, 0, 0);
    chk("post_rst_lft", lft_spd, 38);
    chk("post_rst_rght", rght_spd, -38);
    step(1, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
